// File: rtl/midi_pkg.sv
// Shared constants and FSM state type for the MIDI OUT transmitter.
package midi_pkg;

   localparam logic [7:0] MIDI_STATUS_MIN = 8'h80;
   localparam logic [7:0] MIDI_SYSCOM_MIN = 8'hF0;
   localparam logic [7:0] MIDI_RT_MIN     = 8'hF8;
   localparam int         MIDI_FRAME_BITS = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_START,
      ST_DATA,
      ST_STOP
   } midi_state_e;

endpackage

// File: rtl/midi_tx_fifo.sv
// Byte FIFO with registered flags; pointers carry an extra wrap bit so full
// and empty are told apart by the MSB alone.
module midi_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
   logic             full_q, full_d, empty_q, empty_d;
   logic             push, pop;

   always_comb begin
      push    = push_i && !full_q;
      pop     = pop_i && !empty_q;
      wptr_d  = wptr_q + (AW+1)'(push);
      rptr_d  = rptr_q + (AW+1)'(pop);
      level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
      empty_d = (wptr_d == rptr_d);
      full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   // Storage is not reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

   assign rdata_o = mem_q[rptr_q[AW-1:0]];
   assign full_o  = full_q;
   assign empty_o = empty_q;
   assign level_o = level_q;

endmodule

// File: rtl/midi_out_tx.sv
// MIDI OUT serializer: FIFO-buffered bytes sent as 8N1 frames, with optional
// running-status suppression of repeated channel-status bytes.
module midi_out_tx
   import midi_pkg::*;
#(
   parameter int SYSCLK_F          = 48000000,
   parameter int MIDI_BAUD         = 31250,
   parameter int CLK_PER_BIT       = SYSCLK_F / MIDI_BAUD,
   parameter int FIFO_DEPTH        = 4,
   parameter int RUNNING_STATUS_EN = 1
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst_n,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          MIDI_OUT,
   output logic                          tx_busy,
   output logic                          byte_sent_strobe,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int            TW       = $clog2(CLK_PER_BIT);
   localparam logic [TW-1:0] BIT_LOAD = TW'(CLK_PER_BIT - 1);

   midi_state_e   state_q;
   logic [7:0]    shreg_q, rs_q, head;
   logic          rs_vld_q;
   logic [TW-1:0] timer_q;
   logic [2:0]    idx_q;
   logic          midi_out_q, strobe_q, busy_q;
   logic          fifo_full, fifo_empty, fifo_pop, tx_push;
   logic          is_chan, is_syscom, drop;

   midi_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk     (sys_clk),
      .rst_n   (sys_rst_n),
      .push_i  (tx_valid),
      .pop_i   (fifo_pop),
      .wdata_i (tx_data),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   always_comb begin
      tx_push   = tx_valid && !fifo_full;
      fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
      is_chan   = (shreg_q >= MIDI_STATUS_MIN) && (shreg_q < MIDI_SYSCOM_MIN);
      is_syscom = (shreg_q >= MIDI_SYSCOM_MIN) && (shreg_q < MIDI_RT_MIN);
      drop      = is_chan && (RUNNING_STATUS_EN != 0) && rs_vld_q && (shreg_q == rs_q);
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q    <= ST_IDLE;
         shreg_q    <= '0;
         rs_q       <= '0;
         rs_vld_q   <= 1'b0;
         timer_q    <= '0;
         idx_q      <= '0;
         midi_out_q <= 1'b1;
         strobe_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         strobe_q <= 1'b0;
         busy_q   <= tx_push || !fifo_empty || (state_q != ST_IDLE);
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  shreg_q <= head;
                  state_q <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (drop) begin
                  state_q <= ST_IDLE;
                  busy_q  <= tx_push || !fifo_empty;
               end else begin
                  if (is_chan) begin
                     rs_q     <= shreg_q;
                     rs_vld_q <= 1'b1;
                  end
                  if (is_syscom) rs_vld_q <= 1'b0;
                  state_q    <= ST_START;
                  midi_out_q <= 1'b0;
                  timer_q    <= BIT_LOAD;
               end
            end
            ST_START: begin
               if (timer_q == '0) begin
                  state_q    <= ST_DATA;
                  midi_out_q <= shreg_q[0];
                  idx_q      <= '0;
                  timer_q    <= BIT_LOAD;
               end else begin
                  timer_q <= timer_q - TW'(1);
               end
            end
            ST_DATA: begin
               if (timer_q == '0) begin
                  timer_q <= BIT_LOAD;
                  if (idx_q == 3'd7) begin
                     state_q    <= ST_STOP;
                     midi_out_q <= 1'b1;
                  end else begin
                     idx_q      <= idx_q + 3'd1;
                     midi_out_q <= shreg_q[idx_q + 3'd1];
                  end
               end else begin
                  timer_q <= timer_q - TW'(1);
               end
            end
            ST_STOP: begin
               // Raise the strobe one cycle early so the registered pulse
               // lands on the last stop-bit cycle.
               if (timer_q == TW'(1)) strobe_q <= 1'b1;
               if (timer_q == '0) begin
                  state_q <= ST_IDLE;
                  busy_q  <= tx_push || !fifo_empty;
               end else begin
                  timer_q <= timer_q - TW'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign tx_ready         = !fifo_full;
   assign MIDI_OUT         = midi_out_q;
   assign tx_busy          = busy_q;
   assign byte_sent_strobe = strobe_q;

endmodule

// File: tb/tb_midi_out_tx.sv
// Bench for midi_out_tx: exact-timing check at full baud plus a scoreboarded
// fast-baud instance for running status, backpressure and reset.
module tb_midi_out_tx;
   import midi_pkg::*;

   localparam int CPB_A = 1536;
   localparam int CPB_B = 8;
   localparam int FB    = MIDI_FRAME_BITS;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] a_data, b_data;
   logic       a_valid, b_valid;
   logic       a_ready, a_out, a_busy, a_strobe;
   logic       b_ready, b_out, b_busy, b_strobe;
   logic [2:0] a_level, b_level;

   midi_out_tx #(.CLK_PER_BIT(CPB_A)) u_dut_a (
      .sys_clk(clk), .sys_rst_n(rst_n), .tx_data(a_data), .tx_valid(a_valid),
      .tx_ready(a_ready), .MIDI_OUT(a_out), .tx_busy(a_busy),
      .byte_sent_strobe(a_strobe), .fifo_level(a_level));

   midi_out_tx #(.CLK_PER_BIT(CPB_B)) u_dut_b (
      .sys_clk(clk), .sys_rst_n(rst_n), .tx_data(b_data), .tx_valid(b_valid),
      .tx_ready(b_ready), .MIDI_OUT(b_out), .tx_busy(b_busy),
      .byte_sent_strobe(b_strobe), .fifo_level(b_level));

   always #5 clk = ~clk;

   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         frames_b = 0;
   int         strobes_b = 0;
   bit         chk_gap = 1'b0;
   logic [7:0] exp_q [$];

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (b_strobe === 1'b1) strobes_b <= strobes_b + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_b_idle(input string tag);
      chk({tag, "_b_out"},    32'(b_out),    1);
      chk({tag, "_b_ready"},  32'(b_ready),  1);
      chk({tag, "_b_busy"},   32'(b_busy),   0);
      chk({tag, "_b_strobe"}, 32'(b_strobe), 0);
      chk({tag, "_b_level"},  32'(b_level),  0);
   endtask

   task automatic push_b(input logic [7:0] b);
      int n;
      n = 0;
      b_data  = b;
      b_valid = 1'b1;
      while (!b_ready && n < 500) begin
         tick();
         n++;
      end
      chk("push_wait", 32'(n < 500), 1);
      tick();
      b_valid = 1'b0;
   endtask

   task automatic drain_b(input string tag, input int fr0, input int st0, input int nfr);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || b_busy) && n < 3000) begin
         tick();
         n++;
      end
      chk({tag, "_drain"}, 32'(n < 3000), 1);
      repeat (4) tick();
      chk({tag, "_frames"},  32'(frames_b - fr0),  32'(nfr));
      chk({tag, "_strobes"}, 32'(strobes_b - st0), 32'(nfr));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Line monitor for instance B: decodes each frame and checks it against
   // the head of the expected-byte queue.
   initial begin : mon
      int         last_end, fall, bad, sbad, bi;
      bit         prev_burst, aborted;
      logic [7:0] d;
      last_end   = -100;
      prev_burst = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && b_out === 1'b0) begin
            fall    = cyc;
            bad     = 0;
            sbad    = 0;
            d       = '0;
            aborted = 1'b0;
            if (chk_gap && prev_burst) chk("b2b_gap", 32'(fall - last_end - 1), 2);
            for (int i = 0; i < FB * CPB_B; i++) begin
               if (i > 0) @(negedge clk);
               if (rst_n !== 1'b1) begin
                  aborted = 1'b1;
                  break;
               end
               bi = i / CPB_B;
               if (bi == 0) begin
                  if (b_out !== 1'b0) bad++;
               end else if (bi == FB - 1) begin
                  if (b_out !== 1'b1) bad++;
               end else if (i % CPB_B == 0) begin
                  d[3'(bi - 1)] = b_out;
               end else if (b_out !== d[3'(bi - 1)]) begin
                  bad++;
               end
               if (b_strobe !== (i == FB * CPB_B - 1)) sbad++;
            end
            if (!aborted) begin
               frames_b++;
               last_end   = cyc;
               prev_burst = chk_gap;
               chk("frame_shape", 32'(bad), 0);
               chk("strobe_pos", 32'(sbad), 0);
               chk("frame_expected", 32'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) chk("frame_byte", 32'(d), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      int         bad, strobe_at, fr0, st0, n;
      bit         saw_full, exp_bit;
      logic [7:0] bp [6];
      a_data = '0; a_valid = 1'b0;
      b_data = '0; b_valid = 1'b0;
      rst_n  = 1'b0;
      repeat (3) tick();
      chk_b_idle("in_rst");
      chk("in_rst_a_out",   32'(a_out),   1);
      chk("in_rst_a_ready", 32'(a_ready), 1);
      chk("in_rst_a_level", 32'(a_level), 0);
      rst_n = 1'b1;
      tick();
      chk_b_idle("post_rel");
      chk("post_rel_a_busy", 32'(a_busy), 0);

      // Exact single-frame timing of 0x90 at full baud.
      a_data  = 8'h90;
      a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      chk("a_level_after_push", 32'(a_level), 1);
      chk("a_busy_after_push",  32'(a_busy),  1);
      chk("a_out_n1",           32'(a_out),   1);
      tick();
      chk("a_out_n2",           32'(a_out),   1);
      tick();
      chk("a_out_fall_n3",      32'(a_out),   0);
      bad       = 0;
      strobe_at = -1;
      for (int i = 0; i < FB * CPB_A; i++) begin
         if (i / CPB_A == 0)           exp_bit = 1'b0;
         else if (i / CPB_A == FB - 1) exp_bit = 1'b1;
         else                          exp_bit = a_data[3'(i / CPB_A - 1)];
         if (a_out !== exp_bit) bad++;
         if (a_strobe === 1'b1 && strobe_at < 0) strobe_at = i;
         tick();
      end
      chk("a_frame_bits", 32'(bad), 0);
      chk("a_strobe_cycle", 32'(strobe_at), 15359);
      chk("a_out_after", 32'(a_out), 1);
      chk("a_busy_after", 32'(a_busy), 0);

      // Running status: repeated 0x90 dropped.
      do_reset();
      fr0 = frames_b; st0 = strobes_b;
      exp_q.push_back(8'h90); exp_q.push_back(8'h3C); exp_q.push_back(8'h64);
      exp_q.push_back(8'h3E); exp_q.push_back(8'h00);
      push_b(8'h90); push_b(8'h3C); push_b(8'h64);
      push_b(8'h90); push_b(8'h3E); push_b(8'h00);
      drain_b("rs", fr0, st0, 5);

      // Real-time byte keeps running status.
      do_reset();
      fr0 = frames_b; st0 = strobes_b;
      exp_q.push_back(8'h90); exp_q.push_back(8'h3C); exp_q.push_back(8'h64);
      exp_q.push_back(8'hF8);
      push_b(8'h90); push_b(8'h3C); push_b(8'h64); push_b(8'hF8); push_b(8'h90);
      drain_b("rt", fr0, st0, 4);

      // System common clears it.
      do_reset();
      fr0 = frames_b; st0 = strobes_b;
      exp_q.push_back(8'h90); exp_q.push_back(8'h3C); exp_q.push_back(8'h64);
      exp_q.push_back(8'hF0); exp_q.push_back(8'h90);
      push_b(8'h90); push_b(8'h3C); push_b(8'h64); push_b(8'hF0); push_b(8'h90);
      drain_b("sc", fr0, st0, 5);

      // Backpressure with tx_valid held high.
      do_reset();
      fr0 = frames_b; st0 = strobes_b;
      bp[0] = 8'h12; bp[1] = 8'h34; bp[2] = 8'h56;
      bp[3] = 8'h78; bp[4] = 8'h9A; bp[5] = 8'hBC;
      for (int k = 0; k < 6; k++) exp_q.push_back(bp[k]);
      chk_gap  = 1'b1;
      saw_full = 1'b0;
      b_valid  = 1'b1;
      for (int k = 0; k < 6; k++) begin
         b_data = bp[k];
         n = 0;
         while (!b_ready && n < 500) begin
            chk("bp_level_not_ready", 32'(b_level), 4);
            saw_full = 1'b1;
            tick();
            n++;
         end
         tick();
      end
      b_valid = 1'b0;
      chk("bp_saw_full", 32'(saw_full), 1);
      drain_b("bp", fr0, st0, 6);
      chk_gap = 1'b0;

      // Reset during data bit 3 with two bytes still queued.
      do_reset();
      fr0 = frames_b; st0 = strobes_b;
      push_b(8'h90); push_b(8'h11); push_b(8'h22);
      n = 0;
      while (b_out !== 1'b0 && n < 100) begin
         tick();
         n++;
      end
      chk("rst_frame_started", 32'(n < 100), 1);
      repeat (4 * CPB_B + 2) tick();
      chk("rst_level_before", 32'(b_level), 2);
      rst_n = 1'b0;
      tick();
      chk("rst_edge_out",   32'(b_out),   1);
      chk("rst_edge_level", 32'(b_level), 0);
      chk("rst_edge_ready", 32'(b_ready), 1);
      rst_n = 1'b1;
      tick();
      chk_b_idle("rst_rel");
      repeat (300) tick();
      chk("rst_no_frames",  32'(frames_b - fr0),  0);
      chk("rst_no_strobes", 32'(strobes_b - st0), 0);
      exp_q.push_back(8'h90);
      push_b(8'h90);
      drain_b("rst_after", fr0, st0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/midi_out_tx.md
# midi_out_tx

Serial MIDI transmitter: accepts bytes over a valid/ready interface, buffers them in a 4-entry FIFO, and shifts them out as 8N1 frames at 31250 baud on `MIDI_OUT`. It is the output-side counterpart of the MIDI input path and drives the opto-isolated MIDI OUT/THRU jack. Optional running-status compression drops channel-status bytes that repeat the previous status byte.

## Interface
- `SYSCLK_F`, default 48000000: system clock frequency in Hz.
- `MIDI_BAUD`, default 31250: line bit rate.
- `CLK_PER_BIT`, default `SYSCLK_F/MIDI_BAUD` (1536): sys_clk cycles per bit; must be ≥ 4.
- `FIFO_DEPTH`, default 4: byte buffer depth; must be a power of two.
- `RUNNING_STATUS_EN`, default 1: 1 enables redundant-status suppression.
- `sys_clk` in 1: system clock; all logic runs on its rising edge.
- `sys_rst_n` in 1: synchronous, active-low reset.
- `tx_data` in 8: byte to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: FIFO can accept a byte. Equals `!full`.
- `MIDI_OUT` out 1: serial line. Idle high.
- `tx_busy` out 1: high while a frame is on the line or the FIFO is non-empty.
- `byte_sent_strobe` out 1: one-cycle pulse in the last cycle of each transmitted stop bit.
- `fifo_level` out `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.

## Operation
- Values while `sys_rst_n` is low and in the first cycle after its release:
  - `MIDI_OUT=1`, `tx_ready=1`, `tx_busy=0`, `byte_sent_strobe=0`, `fifo_level=0`.
  - The FIFO is flushed, the running-status register is cleared to invalid, and the FSM is in IDLE.
- **Push.** A byte is written when `tx_valid && tx_ready`. When the FIFO is full, `tx_ready=0` even if a pop occurs in the same cycle; there is no pass-through.
- **FSM states:**
  - **IDLE:** if the FIFO is not empty, pop the head into `shreg` and go to CHECK.
  - **CHECK (1 cycle):** classify the byte.
    - 0x80–0xEF (channel status): if `RUNNING_STATUS_EN` and the byte equals `rs_reg`, discard it and go to IDLE with no line activity. Otherwise set `rs_reg` to the byte and go to START.
    - 0xF0–0xF7 (system common/SysEx): clear `rs_reg` to invalid; go to START.
    - 0xF8–0xFF (real-time): `rs_reg` is unchanged; go to START.
    - 0x00–0x7F (data): `rs_reg` is unchanged; go to START.
  - **START:** `MIDI_OUT=0` for `CLK_PER_BIT` cycles.
  - **DATA:** 8 bits LSB first, each `CLK_PER_BIT` cycles; the 3-bit index counts 0..7.
  - **STOP:** `MIDI_OUT=1` for `CLK_PER_BIT` cycles. Pulse `byte_sent_strobe` in the final cycle, then go to IDLE.
- **Bit timer:** `$clog2(CLK_PER_BIT)` bits wide. It loads `CLK_PER_BIT-1` on entry to START, DATA and STOP, and counts down to 0. It never wraps.
- `MIDI_OUT` is driven from a flop; it is never combinational from FSM state.
- Discarded bytes never pulse `byte_sent_strobe`.

## Timing
- Push into an empty FIFO with the FSM idle:
  - Cycle N: accept.
  - N+1: `fifo_level=1`; IDLE pops.
  - N+2: CHECK.
  - N+3: `MIDI_OUT` falls.
- A frame is exactly `10*CLK_PER_BIT` cycles from the falling edge of the start bit to the end of the stop bit.
- **Back-to-back frames:** the next start bit begins 3 cycles after the stop bit ends (IDLE, CHECK, then START register). The inter-frame gap is therefore 2 extra idle-high cycles.
- A discarded status byte costs 2 cycles (IDLE, CHECK).
- **Reset mid-frame:** `MIDI_OUT` is 1 at the first edge where `sys_rst_n=0`. The partial frame is abandoned and queued bytes are lost.
- `tx_busy` is registered. It rises the cycle after the first accepted push and falls the cycle after STOP completes with an empty FIFO.

## Structure
- Package `midi_pkg` holds:
  - status-class constants `MIDI_STATUS_MIN=8'h80`, `MIDI_SYSCOM_MIN=8'hF0`, `MIDI_RT_MIN=8'hF8`;
  - the 8N1 frame length `MIDI_FRAME_BITS=10`;
  - a state enum type for the FSM.
- Sub-module `midi_tx_fifo`: a synchronous FIFO with `FIFO_DEPTH` entries, registered full, empty and level outputs, and wrap-around pointers one bit wider than the address. The serializer FSM stays in `midi_out_tx`.

## Test plan
- **Single frame.** With `CLK_PER_BIT=1536`, push 0x90.
  - Expect `MIDI_OUT` low 1536 cycles for the start bit, then bits 0,0,0,0,1,0,0,1 at 1536 cycles each, then the stop bit high.
  - Expect `byte_sent_strobe` 15359 cycles after the fall.
- **Running status.** Push 0x90,0x3C,0x64,0x90,0x3E,0x00.
  - Expect 5 frames; the second 0x90 is never on the line.
  - Expect exactly 5 strobes.
- **Real-time vs. system common.** Push 0x90,0x3C,0x64,0xF8,0x90.
  - Expect 4 frames; 0xF8 keeps running status, so the final 0x90 is dropped.
  - Repeat with 0xF0 in place of 0xF8: expect 5 frames.
- **Backpressure.** Hold `tx_valid=1` with 6 distinct bytes while idle.
  - Expect `tx_ready` to drop when `fifo_level=4`.
  - Expect all 6 bytes to be sent in order, each with a 2-cycle extra gap between frames.
- **Reset mid-operation.** Assert `sys_rst_n=0` during data bit 3 with 2 bytes queued.
  - Next edge: `MIDI_OUT=1`, `fifo_level=0`, `tx_ready=1`.
  - After release: no further frames.
  - A subsequent 0x90 is transmitted, since running status was cleared.
